// File: rtl/spu_rpt_pkg.sv
// Shared constants for the SPU<->LSU repeater: PCX packet field positions,
// default widths and the circular-pointer helper used by the request queue.
package spu_rpt_pkg;

    localparam int unsigned PCX_BANK_HI = 71;
    localparam int unsigned PCX_BANK_LO = 70;
    localparam int unsigned PCX_PA_HI   = 103;
    localparam int unsigned PCX_PA_LO   = 68;

    localparam int unsigned DEF_PKT_W      = 123;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_NTHR       = 4;
    localparam int unsigned DEF_TID_W      = 2;
    localparam int unsigned DEF_RS3_STAGES = 3;
    localparam int unsigned DEF_REQ_DEPTH  = 2;

    localparam int unsigned OCC_W = 3;

    function automatic int unsigned ptr_next(input int unsigned p, input int unsigned depth);
        return (p + 1 >= depth) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/spu_rpt_reqq.sv
// PCX request queue: circular buffer with valid/ack handshake, occupancy
// count and a sticky flag for pushes attempted while full.
module spu_rpt_reqq
    import spu_rpt_pkg::*;
#(
    parameter int unsigned PKT_W     = DEF_PKT_W,
    parameter int unsigned REQ_DEPTH = DEF_REQ_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push_vld,
    input  logic [PKT_W-1:0] i_push_pkt,
    output logic             o_push_rdy,
    output logic             o_head_vld,
    output logic [PKT_W-1:0] o_head_pkt,
    input  logic             i_head_ack,
    output logic [OCC_W-1:0] o_occ,
    output logic             o_drop_err
);

    // Storage is sized to the pointer range so every pointer value indexes a real entry.
    localparam int unsigned AW    = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned MEM_N = 1 << AW;

    logic [PKT_W-1:0] r_mem [MEM_N];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_drop;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_occ == OCC_W'(REQ_DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_push  = i_push_vld & ~w_full;
    assign w_pop   = i_head_ack & ~w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= AW'(ptr_next(32'(r_wr_ptr), REQ_DEPTH));
            if (w_pop)
                r_rd_ptr <= AW'(ptr_next(32'(r_rd_ptr), REQ_DEPTH));
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (i_push_vld & w_full)
                r_drop <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_push_pkt;
    end

    assign o_push_rdy = ~w_full;
    assign o_head_vld = ~w_empty;
    assign o_head_pkt = r_mem[r_rd_ptr];
    assign o_occ      = r_occ;
    assign o_drop_err = r_drop;

endmodule

// File: rtl/spu_lsurpt_pipe.sv
// SPU<->LSU repeater/staging: request queue, early bank select, ldxa and
// stb-empty return staging, and the rs3 delay line.
module spu_lsurpt_pipe
    import spu_rpt_pkg::*;
#(
    parameter int unsigned PKT_W      = DEF_PKT_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NTHR       = DEF_NTHR,
    parameter int unsigned TID_W      = DEF_TID_W,
    parameter int unsigned RS3_STAGES = DEF_RS3_STAGES,
    parameter int unsigned REQ_DEPTH  = DEF_REQ_DEPTH
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic              spu_req_vld,
    input  logic [PKT_W-1:0]  spu_req_pkt,
    output logic              spu_req_rdy,
    output logic              lsu_pkt_vld,
    output logic [PKT_W-1:0]  lsu_pkt,
    input  logic              lsu_pkt_ack,
    output logic [1:0]        lsu_bank_early,
    output logic [35:0]       lsu_err_addr,
    output logic [2:0]        req_occ,
    output logic              req_drop_err,
    input  logic [DATA_W-1:0] ldxa_data_in,
    input  logic              ldxa_vld_in,
    input  logic [TID_W-1:0]  ldxa_tid_in,
    input  logic              ldxa_illgl_in,
    output logic [DATA_W-1:0] ldxa_data_out,
    output logic              ldxa_vld_out,
    output logic [TID_W-1:0]  ldxa_tid_out,
    output logic              ldxa_illgl_out,
    input  logic [DATA_W-1:0] rs3_data_in,
    output logic [DATA_W-1:0] rs3_data_out,
    input  logic [NTHR-1:0]   stb_empty_in,
    output logic [NTHR-1:0]   stb_empty_out,
    output logic              stb_all_empty
);

    logic              r_ldxa_vld;
    logic              r_ldxa_illgl;
    logic [DATA_W-1:0] r_ldxa_data;
    logic [TID_W-1:0]  r_ldxa_tid;
    logic [NTHR-1:0]   r_stb_empty;
    logic              r_stb_all;

    spu_rpt_reqq #(
        .PKT_W     (PKT_W),
        .REQ_DEPTH (REQ_DEPTH)
    ) u_reqq (
        .i_clk      (rclk),
        .i_rst      (reset),
        .i_push_vld (spu_req_vld),
        .i_push_pkt (spu_req_pkt),
        .o_push_rdy (spu_req_rdy),
        .o_head_vld (lsu_pkt_vld),
        .o_head_pkt (lsu_pkt),
        .i_head_ack (lsu_pkt_ack),
        .o_occ      (req_occ),
        .o_drop_err (req_drop_err)
    );

    // With the queue empty the incoming packet is the next one the LSU sees.
    assign lsu_bank_early = lsu_pkt_vld ? lsu_pkt[PCX_BANK_HI:PCX_BANK_LO]
                                        : spu_req_pkt[PCX_BANK_HI:PCX_BANK_LO];
    assign lsu_err_addr   = lsu_pkt[PCX_PA_HI:PCX_PA_LO];

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_ldxa_vld   <= 1'b0;
            r_ldxa_illgl <= 1'b0;
            r_stb_empty  <= '1;
            r_stb_all    <= 1'b1;
        end else begin
            r_ldxa_vld   <= ldxa_vld_in;
            r_ldxa_illgl <= ldxa_illgl_in;
            r_stb_empty  <= stb_empty_in;
            r_stb_all    <= &stb_empty_in;
        end
    end

    always_ff @(posedge rclk) begin
        r_ldxa_data <= ldxa_data_in;
        r_ldxa_tid  <= ldxa_tid_in;
    end

    assign ldxa_vld_out   = r_ldxa_vld;
    assign ldxa_illgl_out = r_ldxa_illgl;
    assign ldxa_data_out  = r_ldxa_data;
    assign ldxa_tid_out   = r_ldxa_tid;
    assign stb_empty_out  = r_stb_empty;
    assign stb_all_empty  = r_stb_all;

    for (genvar gi = 0; gi < RS3_STAGES; gi++) begin : g_rs3
        logic [DATA_W-1:0] r_q;
        if (gi == 0) begin : g_first
            always_ff @(posedge rclk) r_q <= rs3_data_in;
        end else begin : g_next
            always_ff @(posedge rclk) r_q <= g_rs3[gi-1].r_q;
        end
    end

    assign rs3_data_out = g_rs3[RS3_STAGES-1].r_q;

endmodule

// File: tb/tb_spu_lsurpt_pipe.sv
// Directed bench for spu_lsurpt_pipe: queued packets are checked by a
// scoreboard monitor on each lsu handshake; side paths are checked inline.
module tb_spu_lsurpt_pipe;

    localparam int unsigned PKT_W  = 123;
    localparam int unsigned DATA_W = 64;

    logic              rclk = 1'b0;
    logic              reset = 1'b0;
    logic              spu_req_vld = 1'b0;
    logic [PKT_W-1:0]  spu_req_pkt = '0;
    logic              spu_req_rdy;
    logic              lsu_pkt_vld;
    logic [PKT_W-1:0]  lsu_pkt;
    logic              lsu_pkt_ack = 1'b0;
    logic [1:0]        lsu_bank_early;
    logic [35:0]       lsu_err_addr;
    logic [2:0]        req_occ;
    logic              req_drop_err;
    logic [DATA_W-1:0] ldxa_data_in = '0;
    logic              ldxa_vld_in = 1'b0;
    logic [1:0]        ldxa_tid_in = '0;
    logic              ldxa_illgl_in = 1'b0;
    logic [DATA_W-1:0] ldxa_data_out;
    logic              ldxa_vld_out;
    logic [1:0]        ldxa_tid_out;
    logic              ldxa_illgl_out;
    logic [DATA_W-1:0] rs3_data_in = '0;
    logic [DATA_W-1:0] rs3_data_out;
    logic [3:0]        stb_empty_in = 4'hF;
    logic [3:0]        stb_empty_out;
    logic              stb_all_empty;

    int n_vec = 0;
    int n_err = 0;
    logic [PKT_W-1:0] sb[$];

    spu_lsurpt_pipe #(
        .PKT_W      (PKT_W),
        .DATA_W     (DATA_W),
        .NTHR       (4),
        .TID_W      (2),
        .RS3_STAGES (3),
        .REQ_DEPTH  (2)
    ) dut (
        .rclk           (rclk),
        .reset          (reset),
        .spu_req_vld    (spu_req_vld),
        .spu_req_pkt    (spu_req_pkt),
        .spu_req_rdy    (spu_req_rdy),
        .lsu_pkt_vld    (lsu_pkt_vld),
        .lsu_pkt        (lsu_pkt),
        .lsu_pkt_ack    (lsu_pkt_ack),
        .lsu_bank_early (lsu_bank_early),
        .lsu_err_addr   (lsu_err_addr),
        .req_occ        (req_occ),
        .req_drop_err   (req_drop_err),
        .ldxa_data_in   (ldxa_data_in),
        .ldxa_vld_in    (ldxa_vld_in),
        .ldxa_tid_in    (ldxa_tid_in),
        .ldxa_illgl_in  (ldxa_illgl_in),
        .ldxa_data_out  (ldxa_data_out),
        .ldxa_vld_out   (ldxa_vld_out),
        .ldxa_tid_out   (ldxa_tid_out),
        .ldxa_illgl_out (ldxa_illgl_out),
        .rs3_data_in    (rs3_data_in),
        .rs3_data_out   (rs3_data_out),
        .stb_empty_in   (stb_empty_in),
        .stb_empty_out  (stb_empty_out),
        .stb_all_empty  (stb_all_empty)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input int n);
        logic [PKT_W-1:0] p;
        logic [31:0] nn;
        nn = 32'(n);
        p = '0;
        p[31:0]    = 32'hA5A5_0000 + nn;
        p[103:68]  = {4'h3, 32'hC0DE_0000 + nn};
        p[71:70]   = nn[1:0];
        p[122:104] = nn[18:0];
        return p;
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic mid();
        @(negedge rclk);
    endtask

    task automatic push(input int n);
        spu_req_vld = 1'b1;
        spu_req_pkt = mk_pkt(n);
    endtask

    // Scoreboard monitor: every head packet the LSU consumes must be the oldest accepted one.
    always @(negedge rclk) begin
        logic [PKT_W-1:0] e;
        if (!reset && lsu_pkt_vld && lsu_pkt_ack) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got pkt %0h expected none", lsu_pkt);
            end else begin
                e = sb.pop_front();
                chk("pkt", 128'(lsu_pkt), 128'(e));
                chk("err_addr", 128'(lsu_err_addr), 128'(e[103:68]));
                chk("bank_head", 128'(lsu_bank_early), 128'(e[71:70]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_rdy", 128'(spu_req_rdy), 128'(1));
        chk("rst_vld", 128'(lsu_pkt_vld), 128'(0));
        chk("rst_occ", 128'(req_occ), 128'(0));
        chk("rst_drop", 128'(req_drop_err), 128'(0));
        chk("rst_ldxa_vld", 128'(ldxa_vld_out), 128'(0));
        chk("rst_ldxa_illgl", 128'(ldxa_illgl_out), 128'(0));
        chk("rst_stb", 128'(stb_empty_out), 128'(4'hF));
        chk("rst_stb_all", 128'(stb_all_empty), 128'(1));
        repeat (4) tick();
        reset = 1'b0;

        // single push with empty queue, bank fast path then head
        tick(); push(1); sb.push_back(mk_pkt(1));
        mid();
        chk("a_bank_push", 128'(lsu_bank_early), 128'(2'd1));
        chk("a_no_bypass", 128'(lsu_pkt_vld), 128'(0));
        tick(); spu_req_vld = 1'b0; spu_req_pkt = mk_pkt(2);
        mid();
        chk("a_vld", 128'(lsu_pkt_vld), 128'(1));
        chk("a_head", 128'(lsu_pkt), 128'(mk_pkt(1)));
        chk("a_bank_head", 128'(lsu_bank_early), 128'(2'd1));
        chk("a_occ", 128'(req_occ), 128'(1));
        tick(); lsu_pkt_ack = 1'b1;
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("a_occ_after", 128'(req_occ), 128'(0));
        chk("a_vld_after", 128'(lsu_pkt_vld), 128'(0));

        // fill, overflow drop, sticky flag
        tick(); push(3); sb.push_back(mk_pkt(3));
        tick(); push(4); sb.push_back(mk_pkt(4));
        mid();
        chk("b_rdy_one", 128'(spu_req_rdy), 128'(1));
        tick(); spu_req_vld = 1'b0;
        mid();
        chk("b_rdy_full", 128'(spu_req_rdy), 128'(0));
        chk("b_occ_full", 128'(req_occ), 128'(2));
        tick(); push(5);
        mid();
        chk("b_drop_pre", 128'(req_drop_err), 128'(0));
        tick(); spu_req_vld = 1'b0;
        mid();
        chk("b_drop", 128'(req_drop_err), 128'(1));
        chk("b_occ_drop", 128'(req_occ), 128'(2));
        tick(); lsu_pkt_ack = 1'b1;
        tick();
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("b_occ_drain", 128'(req_occ), 128'(0));
        chk("b_drop_sticky", 128'(req_drop_err), 128'(1));

        // full queue: simultaneous ack and push, push must be rejected
        tick(); push(6); sb.push_back(mk_pkt(6));
        tick(); push(7); sb.push_back(mk_pkt(7));
        tick(); push(8); lsu_pkt_ack = 1'b1;
        mid();
        chk("c_rdy_full_ack", 128'(spu_req_rdy), 128'(0));
        tick(); push(9); sb.push_back(mk_pkt(9)); lsu_pkt_ack = 1'b0;
        mid();
        chk("c_occ_1", 128'(req_occ), 128'(1));
        chk("c_rdy_1", 128'(spu_req_rdy), 128'(1));
        tick(); spu_req_vld = 1'b0;
        mid();
        chk("c_occ_2", 128'(req_occ), 128'(2));
        tick(); lsu_pkt_ack = 1'b1;
        tick();
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("c_occ_drain", 128'(req_occ), 128'(0));

        // alternate push / ack, pointers wrap repeatedly
        for (int i = 0; i < 16; i++) begin
            tick(); push(16 + i); sb.push_back(mk_pkt(16 + i)); lsu_pkt_ack = 1'b0;
            tick(); spu_req_vld = 1'b0; lsu_pkt_ack = 1'b1;
        end
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("d_occ_end", 128'(req_occ), 128'(0));

        // streaming push+ack in the same cycle keeps occupancy at 1
        tick(); push(40); sb.push_back(mk_pkt(40));
        for (int i = 1; i < 8; i++) begin
            tick(); push(40 + i); sb.push_back(mk_pkt(40 + i)); lsu_pkt_ack = 1'b1;
            mid();
            chk("s_occ_steady", 128'(req_occ), 128'(1));
        end
        tick(); spu_req_vld = 1'b0;
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("s_occ_end", 128'(req_occ), 128'(0));

        // rs3 delay, ldxa and stb staging
        tick();
        rs3_data_in = 64'hDEAD_BEEF_0000_0001;
        ldxa_vld_in = 1'b1; ldxa_tid_in = 2'd2; ldxa_illgl_in = 1'b1;
        ldxa_data_in = 64'h0123_4567_89AB_CDEF;
        stb_empty_in = 4'b0101;
        mid();
        chk("e_stb_hold", 128'(stb_empty_out), 128'(4'hF));
        chk("e_ldxa_hold", 128'(ldxa_vld_out), 128'(0));
        tick();
        rs3_data_in = '0;
        ldxa_vld_in = 1'b0; ldxa_tid_in = 2'd1; ldxa_illgl_in = 1'b0;
        stb_empty_in = 4'hF;
        mid();
        chk("e_ldxa_vld", 128'(ldxa_vld_out), 128'(1));
        chk("e_ldxa_tid", 128'(ldxa_tid_out), 128'(2));
        chk("e_ldxa_illgl", 128'(ldxa_illgl_out), 128'(1));
        chk("e_ldxa_data", 128'(ldxa_data_out), 128'(64'h0123_4567_89AB_CDEF));
        chk("e_stb", 128'(stb_empty_out), 128'(4'b0101));
        chk("e_stb_all0", 128'(stb_all_empty), 128'(0));
        chk("e_rs3_1", 128'(rs3_data_out), 128'(0));
        tick(); mid();
        chk("e_rs3_2", 128'(rs3_data_out), 128'(0));
        chk("e_ldxa_vld0", 128'(ldxa_vld_out), 128'(0));
        chk("e_stb_all1", 128'(stb_all_empty), 128'(1));
        tick(); mid();
        chk("e_rs3_3", 128'(rs3_data_out), 128'(64'hDEAD_BEEF_0000_0001));
        tick(); mid();
        chk("e_rs3_4", 128'(rs3_data_out), 128'(0));

        // asynchronous reset mid-stream
        tick(); push(50); sb.push_back(mk_pkt(50));
        tick(); push(51); sb.push_back(mk_pkt(51));
        tick(); spu_req_vld = 1'b0; stb_empty_in = 4'h0;
        tick();
        mid();
        chk("f_occ_pre", 128'(req_occ), 128'(2));
        chk("f_stb_pre", 128'(stb_empty_out), 128'(4'h0));
        chk("f_drop_pre", 128'(req_drop_err), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("f_vld", 128'(lsu_pkt_vld), 128'(0));
        chk("f_occ", 128'(req_occ), 128'(0));
        chk("f_rdy", 128'(spu_req_rdy), 128'(1));
        chk("f_drop", 128'(req_drop_err), 128'(0));
        chk("f_stb", 128'(stb_empty_out), 128'(4'hF));
        sb.delete();
        stb_empty_in = 4'hF;
        tick();
        tick(); reset = 1'b0;
        tick(); push(60); sb.push_back(mk_pkt(60));
        tick(); spu_req_vld = 1'b0; lsu_pkt_ack = 1'b1;
        tick(); lsu_pkt_ack = 1'b0;
        mid();
        chk("f_occ_post", 128'(req_occ), 128'(0));
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
